// File: rtl/cache_stats_collector.sv
// Per-channel saturating event counters with a 1-cycle registered read port; no backpressure, every rd_req gets a response.
// Optional snapshot bank (snap input, shadow registers) compiled in with CACHE_STATS_SNAPSHOT_EN.
module cache_stats_collector #(
  parameter int NUM_EVENTS  = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int SEL_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_EVENTS-1:0]  event_in,
  input  logic                   count_en,
  input  logic                   clear,
`ifdef CACHE_STATS_SNAPSHOT_EN
  input  logic                   snap,
`endif
  input  logic                   rd_req,
  input  logic [SEL_WIDTH-1:0]   rd_sel,
  output logic                   rd_valid,
  output logic [COUNT_WIDTH-1:0] rd_data,
  output logic                   rd_err,
  output logic [NUM_EVENTS-1:0]  overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rdState_t;

  localparam logic [COUNT_WIDTH-1:0] countMax = '1;

  logic [COUNT_WIDTH-1:0] counters [NUM_EVENTS];
  logic [NUM_EVENTS-1:0]  overflowQ;

  rdState_t               rdState;
  rdState_t               rdStateNext;
  logic [COUNT_WIDTH-1:0] rdDataQ;
  logic [COUNT_WIDTH-1:0] rdDataNext;
  logic                   rdErrQ;
  logic                   rdErrNext;
  logic [COUNT_WIDTH-1:0] selData;
  logic                   selHit;

  // An event at saturation leaves the count alone and only raises the sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) counters[i] <= '0;
      overflowQ <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_EVENTS; i++) counters[i] <= '0;
      overflowQ <= '0;
    end else if (count_en) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (event_in[i]) begin
          if (counters[i] == countMax) begin
            overflowQ[i] <= 1'b1;
          end else begin
            counters[i] <= counters[i] + COUNT_WIDTH'(1);
          end
        end
      end
    end
  end

`ifdef CACHE_STATS_SNAPSHOT_EN
  logic [COUNT_WIDTH-1:0] shadow [NUM_EVENTS];

  // Shadows capture the register values, i.e. before this edge's increment or clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_EVENTS; i++) shadow[i] <= counters[i];
    end
  end
`endif

  always_comb begin
    selData = '0;
    selHit  = 1'b0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (rd_sel == SEL_WIDTH'(i)) begin
        selHit  = 1'b1;
`ifdef CACHE_STATS_SNAPSHOT_EN
        selData = shadow[i];
`else
        selData = counters[i];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdState <= IDLE;
      rdDataQ <= '0;
      rdErrQ  <= 1'b0;
    end else begin
      rdState <= rdStateNext;
      rdDataQ <= rdDataNext;
      rdErrQ  <= rdErrNext;
    end
  end

  always_comb begin
    rdStateNext = IDLE;
    rdDataNext  = rdDataQ;
    rdErrNext   = 1'b0;
    case (rdState)
      IDLE:    if (rd_req) rdStateNext = RESP;
      RESP:    if (rd_req) rdStateNext = RESP;
      default: rdStateNext = IDLE;
    endcase
    if (rd_req) begin
      rdDataNext = selData;
      rdErrNext  = ~selHit;
    end
  end

  assign rd_valid = (rdState == RESP);
  assign rd_data  = rdDataQ;
  assign rd_err   = rdErrQ;
  assign overflow = overflowQ;

endmodule

// File: tb/tb_cache_stats_collector.sv
// Randomized bench for cache_stats_collector against a per-cycle arithmetic model of counts, flags and reads.
module tb_cache_stats_collector;
  localparam int NE   = 4;
  localparam int CW   = 4;
  localparam int SW   = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef CACHE_STATS_SNAPSHOT_EN
  localparam bit SNAP_BUILD = 1'b1;
`else
  localparam bit SNAP_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NE-1:0] event_in = '0;
  logic          count_en = 1'b0;
  logic          clear = 1'b0;
  logic          rd_req = 1'b0;
  logic [SW-1:0] rd_sel = '0;
`ifdef CACHE_STATS_SNAPSHOT_EN
  logic          snap = 1'b0;
`endif
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic          rd_err;
  logic [NE-1:0] overflow;

  int            nChecks = 0;
  int            nFail = 0;
  int            model [NE];
  int            shadowModel [NE];
  logic [NE-1:0] ovfModel;

  cache_stats_collector #(
    .NUM_EVENTS (NE),
    .COUNT_WIDTH(CW),
    .SEL_WIDTH  (SW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .event_in(event_in),
    .count_en(count_en),
    .clear   (clear),
`ifdef CACHE_STATS_SNAPSHOT_EN
    .snap    (snap),
`endif
    .rd_req  (rd_req),
    .rd_sel  (rd_sel),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_err  (rd_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, predict from pre-edge model state, advance model, compare.
  task automatic step(input logic [NE-1:0] ev, input logic en, input logic clr,
                      input logic rq, input logic [SW-1:0] sel, input logic rs, input logic snp);
    logic        expValid;
    logic        expErr;
    logic [31:0] expData;
    event_in = ev;
    count_en = en;
    clear    = clr;
    rd_req   = rq;
    rd_sel   = sel;
    rst      = rs;
`ifdef CACHE_STATS_SNAPSHOT_EN
    snap     = snp;
`endif
    expValid = rq && !rs;
    expErr   = (int'(sel) >= NE);
    expData  = 0;
    if (!expErr) expData = SNAP_BUILD ? shadowModel[sel[1:0]] : model[sel[1:0]];

    @(posedge clk);
    #1;
    if (rs) begin
      for (int i = 0; i < NE; i++) begin
        model[i] = 0;
        shadowModel[i] = 0;
      end
      ovfModel = '0;
    end else begin
      if (snp) for (int i = 0; i < NE; i++) shadowModel[i] = model[i];
      if (clr) begin
        for (int i = 0; i < NE; i++) model[i] = 0;
        ovfModel = '0;
      end else if (en) begin
        for (int i = 0; i < NE; i++) begin
          if (ev[i]) begin
            if (model[i] == CMAX) ovfModel[i] = 1'b1;
            else model[i] = model[i] + 1;
          end
        end
      end
    end

    checkVal("rd_valid", rd_valid, expValid);
    if (expValid) begin
      checkVal("rd_data", rd_data, expData);
      checkVal("rd_err", rd_err, expErr);
    end else begin
      checkVal("rd_err_idle", rd_err, 0);
    end
    if (rs) checkVal("rd_data_reset", rd_data, 0);
    checkVal("overflow", overflow, ovfModel);
    @(negedge clk);
  endtask

  task automatic readAll();
    for (int c = 0; c < NE; c++) step('0, 1'b1, 1'b0, 1'b1, SW'(c), 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NE; i++) begin
      model[i] = 0;
      shadowModel[i] = 0;
    end
    ovfModel = '0;
    @(negedge clk);
    step('0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Two channels counting together, then back-to-back reads of all channels.
    repeat (10) step(4'b0101, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    readAll();

    // Saturation of a 4-bit counter, sticky flag, then clear.
    step('0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    repeat (17) step(4'b0010, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Events coinciding with clear are dropped.
    repeat (3) step(4'b1111, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    readAll();

    // Back-to-back reads including an out-of-range select.
    step('0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // count_en low freezes counters; reset kills a pending read.
    repeat (3) step(4'b1111, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (5) step(4'b1111, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    readAll();
    step('0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Snapshot sequence: shadow holds 3, then 5 after a second snap.
    repeat (3) step(4'b0001, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    repeat (2) step(4'b0001, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      step(NE'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 1) == 1, SW'($urandom), ($urandom_range(0, 149) == 0),
           ($urandom_range(0, 9) == 0));
    end
    step('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    readAll();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
